// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state type and default parameters for serial_frame_capture
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } cap_state_e;

  localparam int DEF_PIX_W       = 8;
  localparam int DEF_NUM_PIX     = 784;
  localparam int DEF_LSB_FIRST   = 1;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/serial_frame_capture_if.sv
// rtl/serial_frame_capture_if.sv - frame buffer write port and frame handshake bundle
//
// Signals:
//   ram_we, ram_addr, ram_din  one-cycle pixel write, ram_addr = {bank, pixel index}
//   frame_done                 one-cycle pulse with the last pixel write of a frame
//   frame_bank, frame_pending  oldest full bank / any bank full
//   frame_ack                  consumer releases frame_bank
// Modports: master = capture side, slave = frame consumer side.
interface serial_frame_capture_if
  import capture_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int AW    = $clog2(DEF_NUM_PIX) + 1
);
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [PIX_W-1:0] ram_din;
  logic             frame_done;
  logic             frame_bank;
  logic             frame_pending;
  logic             frame_ack;

  modport master (
    output ram_we, ram_addr, ram_din, frame_done, frame_bank, frame_pending,
    input  frame_ack
  );

  modport slave (
    input  ram_we, ram_addr, ram_din, frame_done, frame_bank, frame_pending,
    output frame_ack
  );
endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchronizer with rising-edge detector
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   i_async     asynchronous input
//   o_level     synchronized level (last synchronizer flop)
//   o_rise      high for one cycle on a 0->1 step between last sync flop and edge flop
// Parameter SYNC_STAGES must be at least 2.
module edge_sync
  import capture_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_edge;
endmodule

// File: rtl/serial_frame_capture.sv
// rtl/serial_frame_capture.sv - serial pixel stream capture into a two-bank frame buffer
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   serial_data_in   serial pixel data (async)
//   bit_clk_in       bit clock, data taken on its rising edge (async)
//   frame_start_in   rising edge starts (or restarts) a frame (async)
//   bus              serial_frame_capture_if.master: RAM write port and frame handshake
//   busy             high while receiving a frame
//   err_short        pulse: frame restarted before completion
//   err_overrun      pulse: frame start while the write bank is still full
//   err_timeout      pulse: bit clock stalled for TIMEOUT_CYC cycles
// Optional feature macro SERIAL_CAPTURE_TIMEOUT_EN enables the bit clock stall timeout;
// without it err_timeout is tied low. NUM_PIX and PIX_W are expected to be at least 2.
module serial_frame_capture
  import capture_pkg::*;
#(
  parameter int PIX_W       = DEF_PIX_W,
  parameter int NUM_PIX     = DEF_NUM_PIX,
  parameter int LSB_FIRST   = DEF_LSB_FIRST,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_data_in,
  input  logic bit_clk_in,
  input  logic frame_start_in,
  serial_frame_capture_if.master bus,
  output logic busy,
  output logic err_short,
  output logic err_overrun,
  output logic err_timeout
);
  localparam int AW = $clog2(NUM_PIX) + 1;
  localparam int PW = AW - 1;
  localparam int BW = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIX - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PIX_W - 1);

  logic w_data;
  logic w_data_rise_unused;
  logic w_bc_level_unused;
  logic w_bc_rise;
  logic w_fs_level_unused;
  logic w_fs_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .i_async(serial_data_in),
    .o_level(w_data), .o_rise(w_data_rise_unused)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .reset(reset), .i_async(bit_clk_in),
    .o_level(w_bc_level_unused), .o_rise(w_bc_rise)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fstart (
    .clk(clk), .reset(reset), .i_async(frame_start_in),
    .o_level(w_fs_level_unused), .o_rise(w_fs_rise)
  );

  cap_state_e       r_state;
  logic [PW-1:0]    r_pix_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [PIX_W-1:0] r_pix;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_full;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [PIX_W-1:0] r_din;
  logic             r_done;
  logic             r_err_short;
  logic             r_err_over;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC - 1);
  logic [TOW-1:0]   r_to_cnt;
  logic             r_err_to;
`endif

  logic [BW-1:0]    w_cur_bit;
  logic [PW-1:0]    w_cur_pix;
  logic [PIX_W-1:0] w_pix_next;
  logic             w_recv_bit;
  logic             w_pix_done;
  logic             w_frame_done;
  logic             w_ack;
  logic [1:0]       w_full_next;
  logic             w_rd_next;

  always_comb begin
    // A frame_start rise while receiving restarts the frame, so a bit arriving in
    // the same cycle is placed as bit 0 of pixel 0 rather than the stale position.
    w_cur_bit  = w_fs_rise ? '0 : r_bit_cnt;
    w_cur_pix  = w_fs_rise ? '0 : r_pix_cnt;
    w_pix_next = r_pix;
    if (LSB_FIRST != 0) begin
      w_pix_next[w_cur_bit] = w_data;
    end else begin
      w_pix_next[LAST_BIT - w_cur_bit] = w_data;
    end
    w_recv_bit   = (r_state == ST_RECV) && w_bc_rise;
    w_pix_done   = w_recv_bit && (w_cur_bit == LAST_BIT);
    w_frame_done = w_pix_done && (w_cur_pix == LAST_PIX);

    // Release and fill can land in the same cycle on opposite banks.
    w_ack       = bus.frame_ack && (r_full != 2'b00);
    w_full_next = r_full;
    if (w_ack) begin
      w_full_next[r_rd_bank] = 1'b0;
    end
    if (w_frame_done) begin
      w_full_next[r_wr_bank] = 1'b1;
    end
    // The read pointer only moves when its bank is empty and the other is full,
    // which keeps it on the oldest full bank.
    w_rd_next = r_rd_bank;
    if (!w_full_next[r_rd_bank] && w_full_next[~r_rd_bank]) begin
      w_rd_next = ~r_rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pix_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_pix       <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= 2'b00;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_over  <= 1'b0;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err_to    <= 1'b0;
`endif
    end else begin
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_over  <= 1'b0;
      r_full      <= w_full_next;
      r_rd_bank   <= w_rd_next;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
      r_err_to    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE, ST_DROP: begin
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          if (w_fs_rise) begin
            r_pix_cnt <= '0;
            r_bit_cnt <= '0;
            if (!r_full[r_wr_bank]) begin
              r_state <= ST_RECV;
            end else begin
              r_state    <= ST_DROP;
              r_err_over <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (w_fs_rise) begin
            r_err_short <= 1'b1;
          end
          r_pix_cnt <= w_cur_pix;
          r_bit_cnt <= w_cur_bit;
          if (w_recv_bit) begin
            r_pix     <= w_pix_next;
            r_bit_cnt <= w_cur_bit + 1'b1;
            if (w_pix_done) begin
              r_bit_cnt <= '0;
              r_pix_cnt <= w_cur_pix + 1'b1;
              r_we      <= 1'b1;
              r_addr    <= {r_wr_bank, w_cur_pix};
              r_din     <= w_pix_next;
              if (w_frame_done) begin
                r_done    <= 1'b1;
                r_pix_cnt <= '0;
                r_wr_bank <= ~r_wr_bank;
                r_state   <= ST_IDLE;
              end
            end
          end
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
          // Any bit or restart edge rearms the stall counter.
          if (w_bc_rise || w_fs_rise) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt <= '0;
            r_err_to <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_we        = r_we;
  assign bus.ram_addr      = r_addr;
  assign bus.ram_din       = r_din;
  assign bus.frame_done    = r_done;
  assign bus.frame_bank    = r_rd_bank;
  assign bus.frame_pending = |r_full;
  assign busy              = (r_state == ST_RECV);
  assign err_short         = r_err_short;
  assign err_overrun       = r_err_over;
`ifdef SERIAL_CAPTURE_TIMEOUT_EN
  assign err_timeout       = r_err_to;
`else
  assign err_timeout       = 1'b0;
`endif
endmodule
